// File: rtl/ieu_scoreboard.sv
// Decode-stage register scoreboard: tracks destinations owed by fixed- or variable-latency units
// and stalls Decode on RAW/WAW hazards against writes that are still outstanding.
module ieu_scoreboard #(
  parameter int NREGS = 32,
  parameter int NRS   = 3,
  parameter int NWB   = 2,
  parameter int LATW  = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         StallD,
  input  logic                         IssueValidD,
  input  logic [4:0]                   IssueRdD,
  input  logic [LATW-1:0]              IssueLatD,
  input  logic [NRS*5-1:0]             RsD,
  input  logic [NRS-1:0]               RsUsedD,
  input  logic                         FlushE,
  input  logic [NWB-1:0]               WbValidW,
  input  logic [NWB*5-1:0]             WbRdW,
  output logic                         ScoreStallD,
  output logic [NREGS-1:0]             PendingO,
  output logic [$clog2(NREGS+1)-1:0]   BusyCount
);

  localparam int CW = $clog2(NREGS+1);

  logic [NREGS-1:0] pend, isVar, done, pendNext, isVarNext;
  logic [LATW-1:0]  cnt [NREGS];
  logic [LATW-1:0]  cntNext [NREGS];
  logic             lastValid;
  logic [4:0]       lastRd;
  logic             accept;
  logic [CW-1:0]    busyNext;
  logic             rawHit, wawHit;
  logic [4:0]       rsIdx;

  assign accept = IssueValidD & ~StallD & (IssueRdD != 5'd0);

  // Writebacks only complete registers that are actually pending.
  always_comb begin
    done = '0;
    for (int r = 1; r < NREGS; r++) begin
      done[r] = pend[r] & ~isVar[r] & (cnt[r] == LATW'(1));
      for (int j = 0; j < NWB; j++) begin
        if (WbValidW[j] && (WbRdW[5*j +: 5] == 5'(r))) done[r] = done[r] | pend[r];
      end
    end
  end

  // Same-register priority: new accept, then flush of the last accept, then completion.
  always_comb begin
    pendNext  = pend;
    isVarNext = isVar;
    cntNext   = cnt;
    busyNext  = '0;
    for (int r = 1; r < NREGS; r++) begin
      if (accept && (IssueRdD == 5'(r))) begin
        pendNext[r]  = 1'b1;
        isVarNext[r] = (IssueLatD == '0);
        cntNext[r]   = IssueLatD;
      end else if (FlushE && lastValid && (lastRd == 5'(r))) begin
        pendNext[r] = 1'b0;
      end else if (done[r]) begin
        pendNext[r] = 1'b0;
        cntNext[r]  = '0;
      end else if (pend[r] && !isVar[r]) begin
        cntNext[r] = cnt[r] - LATW'(1);
      end
    end
    pendNext[0] = 1'b0;
    for (int r = 0; r < NREGS; r++) busyNext = busyNext + CW'(pendNext[r]);
  end

  always_comb begin
    rawHit = 1'b0;
    rsIdx  = '0;
    for (int i = 0; i < NRS; i++) begin
      rsIdx = RsD[5*i +: 5];
      if (RsUsedD[i] && (rsIdx != 5'd0) && pend[rsIdx] && !done[rsIdx]) rawHit = 1'b1;
    end
    wawHit = IssueValidD && (IssueRdD != 5'd0) && pend[IssueRdD] && !done[IssueRdD];
  end

  assign ScoreStallD = rawHit | wawHit;
  assign PendingO    = pend;

  always_ff @(posedge clk) begin
    if (reset) begin
      pend      <= '0;
      isVar     <= '0;
      lastValid <= 1'b0;
      lastRd    <= '0;
      BusyCount <= '0;
      for (int r = 0; r < NREGS; r++) cnt[r] <= '0;
    end else begin
      pend      <= pendNext;
      isVar     <= isVarNext;
      cnt       <= cntNext;
      lastValid <= accept;
      lastRd    <= IssueRdD;
      BusyCount <= busyNext;
    end
  end

endmodule
